lcd_frame_scheduler: RTL and testbench
======================================

Name: lcd_frame_scheduler

Overview:
Frame-buffer bank scheduler between the SDRAM camera writer and the LCD read path (lcd_driver request/framesync interface). It decides which SDRAM bank the camera writes and which bank the LCD reads, and swaps banks only on LCD frame boundaries so the panel never tears. It also reports dropped frames and exports the SDRAM base address for each side.

Parameters:
ADDR_W, 24, SDRAM word-address width of the base outputs
BANK_STRIDE, 24'h080000, word distance between consecutive banks (must be >= 800*480 = 384000)
DROP_W, 16, width of the dropped-frame counter

Ports:
clk  input  1  system clock, single domain
rst  input  1  synchronous reset, active-high
wr_frame_done  input  1  one-cycle pulse: camera writer finished a full frame in wr_bank
lcd_framesync  input  1  one-cycle pulse from lcd_driver at the start of each LCD frame
wr_hold  output  1  1 = writer must discard incoming frames (no free bank)
wr_bank  output  2  bank currently owned by the writer
rd_bank  output  2  bank currently displayed by the LCD
wr_base  output  ADDR_W  wr_bank*BANK_STRIDE
rd_base  output  ADDR_W  rd_bank*BANK_STRIDE
disp_valid  output  1  1 once rd_bank holds a complete frame; 0 = LCD shows black
swap_pulse  output  1  one-cycle pulse: rd_bank changed this cycle
drop_cnt  output  DROP_W  saturating count of frames lost

Behaviour:
- All outputs are registered. An event on an input cycle N is visible at cycle N+1.
- Reset values: wr_bank=1, rd_bank=0, wr_base=BANK_STRIDE, rd_base=0, wr_hold=0, disp_valid=0, swap_pulse=0, drop_cnt=0, and the internal ready flag is cleared.
- Reset is synchronous and may be asserted mid-frame. All state returns to the reset values on the next edge, and no swap occurs on that edge.
- Base arithmetic: bank 0 -> 0, bank 1 -> BANK_STRIDE, bank 2 -> BANK_STRIDE<<1. Implement with shift/add, not a multiplier. Truncate the result to ADDR_W.
- Double-buffer mode (default), states: WRITE, PEND.
  - WRITE: wr_hold=0. On wr_frame_done go to PEND and set wr_hold=1.
  - PEND: on wr_frame_done, stay in PEND and increment drop_cnt (the writer was told to hold, so the frame is lost).
  - PEND: on lcd_framesync, swap wr_bank and rd_bank, set disp_valid=1, pulse swap_pulse, clear wr_hold, return to WRITE.
  - WRITE: lcd_framesync produces no change.
  - wr_frame_done and lcd_framesync in the same cycle while in WRITE: the done is processed first, then the sync. Swap immediately and stay in WRITE, with wr_hold staying 0.
  - Same coincidence while in PEND: swap, and count one drop.
- drop_cnt saturates at all-ones and never wraps.
- swap_pulse is high for exactly one cycle per swap and is never asserted while rst=1.

Optional Feature:
TRIPLE_BUFFER_EN
- Defined: three banks (0, 1, 2), and wr_hold is tied to 0.
  - Track ready_bank plus a ready flag. The free bank is always 3 - rd_bank - wr_bank.
  - On wr_frame_done with ready flag clear: ready_bank <= wr_bank, wr_bank <= free bank, ready flag set.
  - On wr_frame_done with ready flag set: the old ready frame is superseded. wr_bank and ready_bank exchange, and drop_cnt increments.
  - On lcd_framesync with ready flag set: rd_bank <= ready_bank, the old rd_bank becomes free, ready flag cleared, disp_valid=1, swap_pulse.
  - On lcd_framesync with ready flag clear: no change.
  - Simultaneous done and sync: apply the done first. The just-completed bank becomes rd_bank in the same update, and the writer takes a bank different from both.
  - Reset additionally sets ready flag=0.
- Undefined: double-buffer behaviour above, and no third bank's logic is synthesised.

Test Plan:
- Reset then idle 100 cycles -> wr_bank=1, rd_bank=0, wr_base=0x080000, rd_base=0, disp_valid=0, drop_cnt=0.
- Double mode: wr_frame_done at cycle 10, lcd_framesync at cycle 50 -> wr_hold=1 during cycles 11..50. At cycle 51: rd_bank=1, wr_bank=0, rd_base=0x080000, disp_valid=1, single-cycle swap_pulse.
- Double mode: two wr_frame_done pulses before one framesync -> drop_cnt=1, and exactly one swap occurs.
- Simultaneous wr_frame_done and lcd_framesync in WRITE -> swap next cycle, wr_hold never rises, drop_cnt=0.
- TRIPLE_BUFFER_EN: done, done, sync -> drop_cnt=1. rd_bank equals the bank written second. The three banks stay pairwise distinct on every cycle.
- rst asserted in PEND, with lcd_framesync in the same cycle -> no swap_pulse, and all outputs at reset values the next cycle. Force drop_cnt to 0xFFFF then one more drop -> stays 0xFFFF.

Source files
------------

// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: picks the SDRAM bank the camera writes and the bank the LCD reads, and swaps them only on LCD frame boundaries.
//   Inputs : clk, rst (sync, active-high), wr_frame_done (writer finished wr_bank), lcd_framesync (LCD frame start)
//   Outputs: wr_hold, wr_bank, rd_bank, wr_base, rd_base, disp_valid, swap_pulse, drop_cnt (all registered)
//   Macro  : TRIPLE_BUFFER_EN selects three-bank mode; undefined builds the two-bank (WRITE/PEND) scheduler.
module lcd_frame_scheduler #(
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BANK_STRIDE = 24'h080000,
    parameter int                DROP_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_frame_done,
    input  logic              lcd_framesync,
    output logic              wr_hold,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] rd_base,
    output logic              disp_valid,
    output logic              swap_pulse,
    output logic [DROP_W-1:0] drop_cnt
);
    logic [1:0]        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;
    logic              wr_hold_q, wr_hold_d, disp_valid_q, disp_valid_d, swap_q, swap_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              drop_inc;
`ifdef TRIPLE_BUFFER_EN
    logic              ready_q, ready_d;
    logic [1:0]        ready_bank_q, ready_bank_d, free_bank;
`else
    typedef enum logic {WRITE, PEND} state_t;
    state_t            state_q, state_d;
`endif

    function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] b);
        return b[1] ? (BANK_STRIDE << 1) : (b[0] ? BANK_STRIDE : '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q    <= 2'd1;
            rd_bank_q    <= 2'd0;
            wr_base_q    <= BANK_STRIDE;
            rd_base_q    <= '0;
            wr_hold_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            swap_q       <= 1'b0;
            drop_q       <= '0;
`ifdef TRIPLE_BUFFER_EN
            ready_q      <= 1'b0;
            ready_bank_q <= 2'd2;
`else
            state_q      <= WRITE;
`endif
        end else begin
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_base_q    <= wr_base_d;
            rd_base_q    <= rd_base_d;
            wr_hold_q    <= wr_hold_d;
            disp_valid_q <= disp_valid_d;
            swap_q       <= swap_d;
            drop_q       <= drop_d;
`ifdef TRIPLE_BUFFER_EN
            ready_q      <= ready_d;
            ready_bank_q <= ready_bank_d;
`else
            state_q      <= state_d;
`endif
        end
    end

`ifdef TRIPLE_BUFFER_EN
    // The three banks are always a permutation of {0,1,2}, so the free one is 3 minus the other two.
    // While a frame is ready, the free bank is the ready bank, so a done always hands the writer free_bank;
    // on a coincident done+sync the just-finished bank goes straight to the display.
    always_comb begin
        free_bank    = 2'd3 - rd_bank_q - wr_bank_q;
        swap_d       = lcd_framesync & (ready_q | wr_frame_done);
        drop_inc     = wr_frame_done & ready_q;
        wr_bank_d    = wr_frame_done ? free_bank : wr_bank_q;
        ready_bank_d = wr_frame_done ? wr_bank_q : ready_bank_q;
        rd_bank_d    = swap_d ? (wr_frame_done ? wr_bank_q : ready_bank_q) : rd_bank_q;
        ready_d      = swap_d ? 1'b0 : (ready_q | wr_frame_done);
    end
`else
    // A done in WRITE coinciding with a sync swaps at once, so the writer never sees hold.
    always_comb begin
        swap_d    = lcd_framesync & ((state_q == PEND) | wr_frame_done);
        drop_inc  = wr_frame_done & (state_q == PEND);
        state_d   = swap_d ? WRITE : (wr_frame_done ? PEND : state_q);
        wr_bank_d = swap_d ? rd_bank_q : wr_bank_q;
        rd_bank_d = swap_d ? wr_bank_q : rd_bank_q;
    end
`endif

    always_comb begin
        wr_base_d    = bank_base(wr_bank_d);
        rd_base_d    = bank_base(rd_bank_d);
        disp_valid_d = disp_valid_q | swap_d;
        drop_d       = (drop_inc && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
`ifdef TRIPLE_BUFFER_EN
        wr_hold_d    = 1'b0;
`else
        wr_hold_d    = state_d == PEND;
`endif
    end

    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign wr_base    = wr_base_q;
    assign rd_base    = rd_base_q;
    assign wr_hold    = wr_hold_q;
    assign disp_valid = disp_valid_q;
    assign swap_pulse = swap_q;
    assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb_lcd_frame_scheduler: directed checks of bank swapping, hold, drop counting and reset for lcd_frame_scheduler.
module tb_lcd_frame_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 1'b0, sync = 1'b0, done_s = 1'b0;
    logic        wr_hold, disp_valid, swap_pulse;
    logic [1:0]  wr_bank, rd_bank;
    logic [23:0] wr_base, rd_base;
    logic [15:0] drop_cnt;
    logic        wr_hold_s, disp_valid_s, swap_pulse_s;
    logic [1:0]  wr_bank_s, rd_bank_s;
    logic [23:0] wr_base_s, rd_base_s;
    logic [1:0]  drop_s;
    int          checks = 0, passes = 0, swap_cnt = 0, same_cnt = 0;

    lcd_frame_scheduler dut (
        .clk(clk), .rst(rst), .wr_frame_done(done), .lcd_framesync(sync),
        .wr_hold(wr_hold), .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_base(wr_base), .rd_base(rd_base),
        .disp_valid(disp_valid), .swap_pulse(swap_pulse), .drop_cnt(drop_cnt)
    );

    lcd_frame_scheduler #(.DROP_W(2)) u_sat (
        .clk(clk), .rst(rst), .wr_frame_done(done_s), .lcd_framesync(1'b0),
        .wr_hold(wr_hold_s), .wr_bank(wr_bank_s), .rd_bank(rd_bank_s), .wr_base(wr_base_s), .rd_base(rd_base_s),
        .disp_valid(disp_valid_s), .swap_pulse(swap_pulse_s), .drop_cnt(drop_s)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (swap_pulse) swap_cnt++;
        if (wr_bank == rd_bank) same_cnt++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int sw0;
        rst = 1'b1;
        step;
        step;
        sw0 = swap_cnt;
        rst = 1'b0;
        repeat (100) step;
        checks++;
        if ({wr_bank, rd_bank, wr_hold, disp_valid, swap_pulse} !== {2'd1, 2'd0, 3'b000})
            $display("FAIL reset_flags: got %b want %b", {wr_bank, rd_bank, wr_hold, disp_valid, swap_pulse}, 7'b0100000);
        else passes++;
        checks++;
        if ({wr_base, rd_base} !== {24'h080000, 24'h000000})
            $display("FAIL reset_bases: got %h/%h want 080000/000000", wr_base, rd_base);
        else passes++;
        checks++;
        if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt);
        else passes++;
        checks++;
        if (swap_cnt != sw0) $display("FAIL reset_idle_swaps: got %0d want 0", swap_cnt - sw0);
        else passes++;
    endtask

`ifndef TRIPLE_BUFFER_EN
    task automatic test_single_swap;
        int bad = 0;
        done = 1'b1;
        step;
        done = 1'b0;
        checks++;
        if (wr_hold !== 1'b1) $display("FAIL hold_rise: got %b want 1", wr_hold);
        else passes++;
        repeat (39) begin
            step;
            if (wr_hold !== 1'b1 || swap_pulse !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL hold_window: got %0d bad cycles want 0", bad);
        else passes++;
        sync = 1'b1;
        step;
        sync = 1'b0;
        checks++;
        if ({rd_bank, wr_bank, disp_valid, swap_pulse, wr_hold} !== {2'd1, 2'd0, 3'b110})
            $display("FAIL swap_flags: got %b want %b", {rd_bank, wr_bank, disp_valid, swap_pulse, wr_hold}, 7'b0100110);
        else passes++;
        checks++;
        if ({rd_base, wr_base} !== {24'h080000, 24'h000000})
            $display("FAIL swap_bases: got %h/%h want 080000/000000", rd_base, wr_base);
        else passes++;
        step;
        checks++;
        if (swap_pulse !== 1'b0) $display("FAIL swap_width: got %b want 0", swap_pulse);
        else passes++;
    endtask

    task automatic test_double_drop;
        int sw0;
        done = 1'b1;
        step;
        done = 1'b0;
        step;
        done = 1'b1;
        step;
        done = 1'b0;
        checks++;
        if ({drop_cnt, wr_hold} !== {16'd1, 1'b1}) $display("FAIL drop_one: got %0d/%b want 1/1", drop_cnt, wr_hold);
        else passes++;
        sw0 = swap_cnt;
        sync = 1'b1;
        step;
        sync = 1'b0;
        checks++;
        if ({rd_bank, wr_bank, swap_pulse, wr_hold} !== {2'd0, 2'd1, 2'b10})
            $display("FAIL drop_swap: got %b want 000110", {rd_bank, wr_bank, swap_pulse, wr_hold});
        else passes++;
        repeat (3) step;
        checks++;
        if (swap_cnt - sw0 != 1) $display("FAIL drop_swap_count: got %0d want 1", swap_cnt - sw0);
        else passes++;
    endtask

    task automatic test_simultaneous;
        int sw0;
        logic hold_seen = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        sw0 = swap_cnt;
        done = 1'b1;
        sync = 1'b1;
        step;
        done = 1'b0;
        sync = 1'b0;
        hold_seen = wr_hold;
        checks++;
        if ({rd_bank, wr_bank, swap_pulse, disp_valid} !== {2'd1, 2'd0, 2'b11})
            $display("FAIL simul_swap: got %b want 010011", {rd_bank, wr_bank, swap_pulse, disp_valid});
        else passes++;
        repeat (5) begin
            step;
            hold_seen = hold_seen | wr_hold;
        end
        checks++;
        if ({hold_seen, drop_cnt} !== {1'b0, 16'd0}) $display("FAIL simul_hold_drop: got %b/%0d want 0/0", hold_seen, drop_cnt);
        else passes++;
        checks++;
        if (swap_cnt - sw0 != 1) $display("FAIL simul_swap_count: got %0d want 1", swap_cnt - sw0);
        else passes++;
    endtask

    task automatic test_pend_coincide;
        done = 1'b1;
        step;
        done = 1'b0;
        checks++;
        if (wr_hold !== 1'b1) $display("FAIL pend_enter: got %b want 1", wr_hold);
        else passes++;
        done = 1'b1;
        sync = 1'b1;
        step;
        done = 1'b0;
        sync = 1'b0;
        checks++;
        if ({rd_bank, wr_bank, swap_pulse, wr_hold, drop_cnt} !== {2'd0, 2'd1, 2'b10, 16'd1})
            $display("FAIL pend_coincide: got %b/%b/%b/%b/%0d want 0/1/1/0/1", rd_bank, wr_bank, swap_pulse, wr_hold, drop_cnt);
        else passes++;
    endtask

    task automatic test_reset_in_pend;
        done = 1'b1;
        step;
        done = 1'b0;
        rst = 1'b1;
        sync = 1'b1;
        step;
        rst = 1'b0;
        sync = 1'b0;
        checks++;
        if ({swap_pulse, wr_bank, rd_bank, wr_hold, disp_valid} !== {1'b0, 2'd1, 2'd0, 2'b00})
            $display("FAIL rst_pend_flags: got %b want 0010000", {swap_pulse, wr_bank, rd_bank, wr_hold, disp_valid});
        else passes++;
        checks++;
        if ({wr_base, rd_base, drop_cnt} !== {24'h080000, 24'h000000, 16'd0})
            $display("FAIL rst_pend_vals: got %h/%h/%0d want 080000/000000/0", wr_base, rd_base, drop_cnt);
        else passes++;
        step;
        checks++;
        if ({swap_pulse, wr_hold} !== 2'b00) $display("FAIL rst_pend_after: got %b want 00", {swap_pulse, wr_hold});
        else passes++;
    endtask

    task automatic test_saturation;
        logic [1:0] exp;
        done_s = 1'b1;
        step;
        done_s = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp = (k > 3) ? 2'd3 : 2'(k);
            done_s = 1'b1;
            step;
            done_s = 1'b0;
            checks++;
            if (drop_s !== exp) $display("FAIL sat_drop_%0d: got %0d want %0d", k, drop_s, exp);
            else passes++;
        end
    endtask
`else
    task automatic test_triple;
        rst = 1'b1;
        step;
        rst = 1'b0;
        done = 1'b1;
        step;
        done = 1'b0;
        checks++;
        if ({wr_bank, rd_bank, wr_hold, swap_pulse} !== {2'd2, 2'd0, 2'b00})
            $display("FAIL tri_done1: got %b want 100000", {wr_bank, rd_bank, wr_hold, swap_pulse});
        else passes++;
        done = 1'b1;
        step;
        done = 1'b0;
        checks++;
        if ({wr_bank, drop_cnt} !== {2'd1, 16'd1}) $display("FAIL tri_done2: got %0d/%0d want 1/1", wr_bank, drop_cnt);
        else passes++;
        sync = 1'b1;
        step;
        sync = 1'b0;
        checks++;
        if ({rd_bank, wr_bank, swap_pulse, disp_valid} !== {2'd2, 2'd1, 2'b11})
            $display("FAIL tri_sync: got %b want 100111", {rd_bank, wr_bank, swap_pulse, disp_valid});
        else passes++;
        checks++;
        if ({rd_base, wr_base} !== {24'h100000, 24'h080000})
            $display("FAIL tri_bases: got %h/%h want 100000/080000", rd_base, wr_base);
        else passes++;
        done = 1'b1;
        sync = 1'b1;
        step;
        done = 1'b0;
        sync = 1'b0;
        checks++;
        if ({rd_bank, wr_bank, swap_pulse, drop_cnt} !== {2'd1, 2'd0, 1'b1, 16'd1})
            $display("FAIL tri_simul: got %0d/%0d/%b/%0d want 1/0/1/1", rd_bank, wr_bank, swap_pulse, drop_cnt);
        else passes++;
    endtask
`endif

    task automatic test_invariants;
        checks++;
        if (same_cnt != 0) $display("FAIL bank_distinct: got %0d collisions want 0", same_cnt);
        else passes++;
    endtask

    initial begin
        test_reset;
`ifndef TRIPLE_BUFFER_EN
        test_single_swap;
        test_double_drop;
        test_simultaneous;
        test_pend_coincide;
        test_reset_in_pend;
        test_saturation;
`else
        test_triple;
`endif
        test_invariants;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
